// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage SRAM access controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } ctrlState_t;

    localparam logic PHASE_LOW  = 1'b0;
    localparam logic PHASE_HIGH = 1'b1;

    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Half-word phase timer: counts 0..WAIT_CYCLES-1, flags the last two counts.
module sram_phase_timer
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last,
    output logic nearLast
);

    localparam int CW = clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] NEAR_CNT = CW'(WAIT_CYCLES - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign last     = (count == LAST_CNT);
    assign nearLast = (count == NEAR_CNT);

endmodule

// File: rtl/sram_access_ctrl.sv
// MEM-stage controller: one 32-bit access as two 16-bit SRAM phases.
// Optional one-entry load buffer enabled by SRAM_READ_BUFFER_EN.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 18,
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [31:0]       address,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    output logic              ready,
    output logic [ADDR_W-1:0] sramAddr,
    output logic [15:0]       sramDqOut,
    input  logic [15:0]       sramDqIn,
    output logic              sramDqOe,
    output logic              sramWeN
);

    ctrlState_t        state;
    logic              isStore;
    logic [ADDR_W-2:0] lineAddr;
    logic [31:0]       wData;
    logic [31:0]       eff;
    logic              req;
    logic              hit;
    logic              start;
    logic              last;
    logic              nearLast;
    logic              inPhase;
    logic              unusedBits;

    assign eff        = address - BASE_ADDR;
    assign unusedBits = ^{eff[31:ADDR_W+1], eff[1:0]};
    assign req        = memRead | memWrite;

`ifdef SRAM_READ_BUFFER_EN
    logic [ADDR_W-2:0] bufTag;
    logic              bufValid;

    assign hit = memRead & ~memWrite & bufValid
               & (bufTag == eff[ADDR_W:2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bufValid <= 1'b0;
            bufTag   <= '0;
        end else if (state == DONE) begin
            bufValid <= ~isStore;
            if (!isStore) bufTag <= lineAddr;
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign start   = (state == IDLE) & req & ~hit;
    assign inPhase = (state == LOW) | (state == HIGH);
    assign ready   = (state == DONE) | ((state == IDLE) & ~start);

    sram_phase_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) uTimer (
        .clk     (clk),
        .rst     (rst),
        .clr     (start | last),
        .en      (inPhase),
        .last    (last),
        .nearLast(nearLast)
    );

    // Write strobe drops on phase entry and rises one cycle before the
    // phase ends so address and data stay valid past the WE edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            isStore   <= 1'b0;
            lineAddr  <= '0;
            wData     <= '0;
            readData  <= '0;
            sramAddr  <= '0;
            sramDqOut <= '0;
            sramDqOe  <= 1'b0;
            sramWeN   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOW;
                        isStore   <= memWrite;
                        lineAddr  <= eff[ADDR_W:2];
                        wData     <= writeData;
                        sramAddr  <= {eff[ADDR_W:2], PHASE_LOW};
                        sramDqOut <= writeData[15:0];
                        sramDqOe  <= memWrite;
                        sramWeN   <= ~memWrite;
                    end
                end
                LOW: begin
                    if (nearLast) sramWeN <= 1'b1;
                    if (last) begin
                        state     <= HIGH;
                        sramAddr  <= {lineAddr, PHASE_HIGH};
                        sramDqOut <= wData[31:16];
                        sramWeN   <= ~isStore;
                        if (!isStore) readData[15:0] <= sramDqIn;
                    end
                end
                HIGH: begin
                    if (nearLast) sramWeN <= 1'b1;
                    if (last) begin
                        state    <= DONE;
                        sramDqOe <= 1'b0;
                        sramWeN  <= 1'b1;
                        if (!isStore) readData[31:16] <= sramDqIn;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
